// File: rtl/map_ss_pkg.sv
// map_ss_pkg: shared types and defaults for the mapper save-state sequencer.
//   state_e         - sequencer FSM states
//   SS_LEN_DEF      - default snapshot length in bytes
//   WE_LEN_DEF      - default restore write-strobe length in cycles
//   RD_LAT_DEF      - default mapper readback latency in cycles
//   wait_cnt_width  - width of the shared wait counter for given latencies
package map_ss_pkg;

  localparam int unsigned SS_LEN_DEF = 128;
  localparam int unsigned WE_LEN_DEF = 4;
  localparam int unsigned RD_LAT_DEF = 1;

  typedef enum logic [2:0] {
    IDLE,
    SV_ADDR,
    SV_WR,
    LD_REQ,
    LD_SETUP,
    LD_WE,
    LD_HOLD,
    FIN
  } state_e;

  // One counter serves both the readback wait and the write-strobe wait,
  // so it must hold the larger of the two.
  function automatic int unsigned wait_cnt_width(input int unsigned rd_lat,
                                                 input int unsigned we_len);
    int unsigned m;
    m = (rd_lat > we_len) ? rd_lat : we_len;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/map_ss_seq_if.sv
// map_ss_seq_if: save-state port towards the active mapper plus the
// snapshot memory request port.
//   ss_act/ss_we/ss_addr/ss_wdat  - sequencer -> mapper
//   ss_rdat                       - mapper -> sequencer readback
//   mem_req/mem_wr/mem_addr/mem_wdat - sequencer -> snapshot memory
//   mem_rdat/mem_ack              - snapshot memory -> sequencer
// master: the sequencer side; slave: the mapper/memory side.
interface map_ss_seq_if;

  logic       ss_act;
  logic       ss_we;
  logic [7:0] ss_addr;
  logic [7:0] ss_wdat;
  logic [7:0] ss_rdat;

  logic       mem_req;
  logic       mem_wr;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdat;
  logic [7:0] mem_rdat;
  logic       mem_ack;

  modport master (
    output ss_act, ss_we, ss_addr, ss_wdat,
    input  ss_rdat,
    output mem_req, mem_wr, mem_addr, mem_wdat,
    input  mem_rdat, mem_ack
  );

  modport slave (
    input  ss_act, ss_we, ss_addr, ss_wdat,
    output ss_rdat,
    input  mem_req, mem_wr, mem_addr, mem_wdat,
    output mem_rdat, mem_ack
  );

endinterface

// File: rtl/map_ss_timer.sv
// map_ss_timer: loadable down-counter with a terminal-count flag.
//   clk       - system clock
//   rst_n     - synchronous active-low reset
//   load      - load load_val this edge (takes priority over counting)
//   load_val  - value loaded; zero is reached load_val cycles later
//   zero      - counter is at terminal count
// The counter parks at zero rather than wrapping.
module map_ss_timer #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/map_ss_seq.sv
// map_ss_seq: save-state sequencer, initiator side of the mapper save-state
// port. A save walks ss_addr 0..SS_LEN-1, samples ss_rdat and writes each
// byte to snapshot memory; a load reads each byte back and replays it into
// the mapper with an ss_we strobe of WE_LEN cycles.
//   clk, rst_n             - system clock, synchronous active-low reset
//   start_save, start_load - 1-cycle command pulses (save wins a tie)
//   abort                  - return to IDLE on the next edge
//   busy                   - high in every non-IDLE state
//   done                   - 1-cycle pulse on normal completion
//   bus                    - mapper save-state port and snapshot memory port
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a command
// SV_ADDR  | ss_addr driven, waiting RD_LAT cycles for ss_rdat
// SV_WR    | writing captured byte to snapshot memory, waiting for ack
// LD_REQ   | reading byte idx from snapshot memory, waiting for ack
// LD_SETUP | ss_addr/ss_wdat presented one cycle ahead of the strobe
// LD_WE    | ss_we high for WE_LEN cycles
// LD_HOLD  | ss_we low, address/data held one more cycle
// FIN      | done pulse, ss_act low
module map_ss_seq
  import map_ss_pkg::*;
#(
  parameter int unsigned SS_LEN = SS_LEN_DEF,
  parameter int unsigned RD_LAT = RD_LAT_DEF,
  parameter int unsigned WE_LEN = WE_LEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_save,
  input  logic            start_load,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  map_ss_seq_if.master    bus
);

  localparam int unsigned      CNT_W    = wait_cnt_width(RD_LAT, WE_LEN);
  localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WE_LOAD  = CNT_W'(WE_LEN - 1);
  localparam logic [7:0]       LAST_IDX = 8'(SS_LEN - 1);

  state_e           state_q, state_d;
  logic [7:0]       idx_q, idx_d;
  logic [7:0]       ss_addr_q, ss_addr_d;
  logic [7:0]       ss_wdat_q, ss_wdat_d;
  logic [7:0]       mem_wdat_q, mem_wdat_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;

  logic             last_idx;

  assign last_idx = (idx_q == LAST_IDX);

  map_ss_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // ss_addr is a separate register from idx so that it only moves on
  // SV_ADDR / LD_SETUP entry; idx advances earlier, on LD_HOLD exit.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ss_addr_d  = ss_addr_q;
    ss_wdat_d  = ss_wdat_q;
    mem_wdat_d = mem_wdat_q;
    tmr_load   = 1'b0;
    tmr_val    = RD_LOAD;

    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_save) begin
            state_d   = SV_ADDR;
            idx_d     = 8'd0;
            ss_addr_d = 8'd0;
            tmr_load  = 1'b1;
            tmr_val   = RD_LOAD;
          end else if (start_load) begin
            state_d = LD_REQ;
            idx_d   = 8'd0;
          end
        end

        SV_ADDR: begin
          if (tmr_zero) begin
            mem_wdat_d = bus.ss_rdat;
            state_d    = SV_WR;
          end
        end

        SV_WR: begin
          if (bus.mem_ack) begin
            if (last_idx) begin
              state_d = FIN;
            end else begin
              idx_d     = idx_q + 8'd1;
              ss_addr_d = idx_q + 8'd1;
              tmr_load  = 1'b1;
              tmr_val   = RD_LOAD;
              state_d   = SV_ADDR;
            end
          end
        end

        LD_REQ: begin
          if (bus.mem_ack) begin
            ss_wdat_d = bus.mem_rdat;
            ss_addr_d = idx_q;
            state_d   = LD_SETUP;
          end
        end

        LD_SETUP: begin
          tmr_load = 1'b1;
          tmr_val  = WE_LOAD;
          state_d  = LD_WE;
        end

        LD_WE: begin
          if (tmr_zero) begin
            state_d = LD_HOLD;
          end
        end

        LD_HOLD: begin
          if (last_idx) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = LD_REQ;
          end
        end

        FIN: begin
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 8'd0;
      ss_addr_q  <= 8'd0;
      ss_wdat_q  <= 8'd0;
      mem_wdat_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ss_addr_q  <= ss_addr_d;
      ss_wdat_q  <= ss_wdat_d;
      mem_wdat_q <= mem_wdat_d;
    end
  end

  // Control outputs decode straight from the registered state, so abort
  // and reset drop them on the same edge that returns the FSM to IDLE.
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FIN);
  assign bus.ss_act   = (state_q != IDLE) && (state_q != FIN);
  assign bus.ss_we    = (state_q == LD_WE);
  assign bus.ss_addr  = ss_addr_q;
  assign bus.ss_wdat  = ss_wdat_q;
  assign bus.mem_req  = (state_q == SV_WR) || (state_q == LD_REQ);
  assign bus.mem_wr   = (state_q == SV_WR);
  assign bus.mem_addr = idx_q;
  assign bus.mem_wdat = mem_wdat_q;

endmodule

// File: tb/tb_map_ss_seq.sv
module tb_map_ss_seq;

  localparam int SS_LEN = 128;
  localparam int WE_LEN = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic start_save;
  logic start_load;
  logic abort;
  logic busy;
  logic done;

  logic fill_req;
  logic late_ack;
  logic rand_en;

  always #5 clk = ~clk;

  map_ss_seq_if bus ();

  map_ss_seq #(
    .SS_LEN (SS_LEN),
    .RD_LAT (1),
    .WE_LEN (WE_LEN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_save (start_save),
    .start_load (start_load),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  // mapper and snapshot memory models
  bit [7:0] mem  [256];
  bit [7:0] regs [256];
  int wait_cnt;
  int ack_delay;
  int wr_cnt;
  int rd_cnt;

  assign bus.ss_rdat  = bus.ss_addr ^ 8'hA5;
  assign bus.mem_rdat = mem[bus.mem_addr];
  assign bus.mem_ack  = (bus.mem_req && (wait_cnt >= ack_delay)) || late_ack;

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < 256; i++) begin
        mem[i]  <= 8'(i + 3);
        regs[i] <= 8'h00;
      end
    end else begin
      if (bus.mem_req && bus.mem_ack) begin
        if (bus.mem_wr) begin
          mem[bus.mem_addr] <= bus.mem_wdat;
          wr_cnt <= wr_cnt + 1;
        end else begin
          rd_cnt <= rd_cnt + 1;
        end
      end
      if (bus.ss_act && bus.ss_we) regs[bus.ss_addr] <= bus.ss_wdat;
    end
    if (bus.mem_req && bus.mem_ack) begin
      wait_cnt  <= 0;
      ack_delay <= rand_en ? int'($urandom_range(0, 5)) : 0;
    end else if (bus.mem_req) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  // protocol monitors
  int done_cnt;
  int we_cnt;
  int mem_viol;
  int we_viol;
  int we_run;
  bit pend_q, ab_q, rst_q, we_p, m_wr_p;
  bit [7:0] m_addr_p, m_wdat_p, s_addr_p, s_wdat_p;

  always @(posedge clk) begin
    if (bus.ss_we) we_cnt <= we_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (pend_q && !ab_q && rst_q &&
        (!bus.mem_req || bus.mem_addr != m_addr_p ||
         bus.mem_wdat != m_wdat_p || bus.mem_wr != m_wr_p))
      mem_viol <= mem_viol + 1;
    if (!ab_q && rst_q) begin
      if ((bus.ss_we || we_p) &&
          (bus.ss_addr != s_addr_p || bus.ss_wdat != s_wdat_p || !bus.ss_act))
        we_viol <= we_viol + 1;
      if (!bus.ss_we && we_p && we_run != WE_LEN)
        we_viol <= we_viol + 1;
    end
    we_run   <= bus.ss_we ? we_run + 1 : 0;
    pend_q   <= bus.mem_req && !bus.mem_ack;
    m_addr_p <= bus.mem_addr;
    m_wdat_p <= bus.mem_wdat;
    m_wr_p   <= bus.mem_wr;
    we_p     <= bus.ss_we;
    s_addr_p <= bus.ss_addr;
    s_wdat_p <= bus.ss_wdat;
    ab_q     <= abort;
    rst_q    <= rst_n;
  end

  int n_cmp;
  int n_err;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill();
    fill_req = 1'b1;
    step();
    fill_req = 1'b0;
  endtask

  task automatic run_cmd(input bit s, input bit l, input int budget, output int n);
    start_save = s;
    start_load = l;
    step();
    start_save = 1'b0;
    start_load = 1'b0;
    n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    check("done_seen", 64'(done), 64'd1);
  endtask

  function automatic int save_bad();
    int b = 0;
    for (int i = 0; i < SS_LEN; i++)
      if (mem[i] != (8'(i) ^ 8'hA5)) b++;
    return b;
  endfunction

  function automatic int regs_bad();
    int b = 0;
    for (int i = 0; i < SS_LEN; i++)
      if (regs[i] != 8'(i + 3)) b++;
    return b;
  endfunction

  // outputs: {busy,done,ss_act,ss_we,mem_req,mem_wr}, ss_addr, mem_addr, ss_wdat, mem_wdat
  typedef struct packed {
    logic       sv;
    logic       ld;
    logic       ab;
    logic [5:0] ctl;
    logic [7:0] ss_addr;
    logic [7:0] mem_addr;
    logic [7:0] ss_wdat;
    logic [7:0] mem_wdat;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int n;
    int w0, r0, d0, e0, mv0, wv0;
    bit hit;
    logic [37:0] obs, exp;

    rst_n = 1'b0; start_save = 1'b0; start_load = 1'b0; abort = 1'b0;
    fill_req = 1'b0; late_ack = 1'b0; rand_en = 1'b0;
    n_cmp = 0; n_err = 0;

    //            sv    ld    ab    ctl        ss_a   mem_a  ss_wd  mem_wd
    tbl[0]  = {1'b0, 1'b0, 1'b0, 6'b000000, 8'h00, 8'h00, 8'h00, 8'h00}; // reset idle
    tbl[1]  = {1'b1, 1'b1, 1'b0, 6'b101000, 8'h00, 8'h00, 8'h00, 8'h00}; // tie -> SV_ADDR
    tbl[2]  = {1'b0, 1'b1, 1'b0, 6'b101011, 8'h00, 8'h00, 8'h00, 8'hA5}; // SV_WR, load ignored
    tbl[3]  = {1'b0, 1'b0, 1'b0, 6'b101000, 8'h01, 8'h01, 8'h00, 8'hA5}; // SV_ADDR idx1
    tbl[4]  = {1'b0, 1'b0, 1'b0, 6'b101011, 8'h01, 8'h01, 8'h00, 8'hA4}; // SV_WR idx1
    tbl[5]  = {1'b0, 1'b0, 1'b1, 6'b000000, 8'h01, 8'h01, 8'h00, 8'hA4}; // abort
    tbl[6]  = {1'b0, 1'b1, 1'b0, 6'b101010, 8'h01, 8'h00, 8'h00, 8'hA4}; // LD_REQ idx0
    tbl[7]  = {1'b0, 1'b0, 1'b0, 6'b101000, 8'h00, 8'h00, 8'hA5, 8'hA4}; // LD_SETUP
    tbl[8]  = {1'b0, 1'b0, 1'b0, 6'b101100, 8'h00, 8'h00, 8'hA5, 8'hA4}; // LD_WE 1
    tbl[9]  = {1'b0, 1'b0, 1'b0, 6'b101100, 8'h00, 8'h00, 8'hA5, 8'hA4}; // LD_WE 2
    tbl[10] = {1'b0, 1'b0, 1'b0, 6'b101100, 8'h00, 8'h00, 8'hA5, 8'hA4}; // LD_WE 3
    tbl[11] = {1'b0, 1'b0, 1'b0, 6'b101100, 8'h00, 8'h00, 8'hA5, 8'hA4}; // LD_WE 4
    tbl[12] = {1'b0, 1'b0, 1'b0, 6'b101000, 8'h00, 8'h00, 8'hA5, 8'hA4}; // LD_HOLD
    tbl[13] = {1'b0, 1'b0, 1'b0, 6'b101010, 8'h00, 8'h01, 8'hA5, 8'hA4}; // LD_REQ idx1
    tbl[14] = {1'b0, 1'b0, 1'b1, 6'b000000, 8'h00, 8'h01, 8'hA5, 8'hA4}; // abort beats ack
    tbl[15] = {1'b0, 1'b1, 1'b1, 6'b000000, 8'h00, 8'h01, 8'hA5, 8'hA4}; // abort beats cmd

    repeat (3) step();
    rst_n = 1'b1;

    for (int k = 0; k < 16; k++) begin
      start_save = tbl[k].sv;
      start_load = tbl[k].ld;
      abort      = tbl[k].ab;
      step();
      start_save = 1'b0;
      start_load = 1'b0;
      abort      = 1'b0;
      obs = {busy, done, bus.ss_act, bus.ss_we, bus.mem_req, bus.mem_wr,
             bus.ss_addr, bus.mem_addr, bus.ss_wdat, bus.mem_wdat};
      exp = {tbl[k].ctl, tbl[k].ss_addr, tbl[k].mem_addr, tbl[k].ss_wdat, tbl[k].mem_wdat};
      check($sformatf("vec%0d", k), 64'(obs), 64'(exp));
    end

    // full save, zero-wait memory: done on the 257th edge counting accept
    fill();
    w0 = wr_cnt; e0 = we_cnt; mv0 = mem_viol;
    run_cmd(1'b1, 1'b0, 2000, n);
    check("save_cycles", 64'(n), 64'd256);
    check("save_writes", 64'(wr_cnt - w0), 64'd128);
    check("save_data", 64'(save_bad()), 64'd0);
    check("save_no_we", 64'(we_cnt - e0), 64'd0);
    step();
    check("save_busy_fall", 64'(busy), 64'd0);

    // full load, zero-wait memory: 7 cycles per byte
    fill();
    wv0 = we_viol; e0 = we_cnt;
    run_cmd(1'b0, 1'b1, 3000, n);
    check("load_cycles", 64'(n), 64'd896);
    check("load_regs", 64'(regs_bad()), 64'd0);
    check("load_we_timing", 64'(we_viol - wv0), 64'd0);
    check("load_we_cycles", 64'(we_cnt - e0), 64'd512);
    step();

    // random memory wait states
    rand_en = 1'b1;
    fill();
    w0 = wr_cnt; mv0 = mem_viol;
    run_cmd(1'b1, 1'b0, 4000, n);
    check("wait_save_slower", 64'(n > 256), 64'd1);
    check("wait_save_writes", 64'(wr_cnt - w0), 64'd128);
    check("wait_save_data", 64'(save_bad()), 64'd0);
    check("wait_save_stable", 64'(mem_viol - mv0), 64'd0);
    step();
    fill();
    mv0 = mem_viol; wv0 = we_viol;
    run_cmd(1'b0, 1'b1, 6000, n);
    check("wait_load_regs", 64'(regs_bad()), 64'd0);
    check("wait_load_stable", 64'(mem_viol - mv0), 64'd0);
    check("wait_load_we", 64'(we_viol - wv0), 64'd0);
    rand_en = 1'b0;
    step();

    // tie goes to save, later load command ignored, one done
    fill();
    d0 = done_cnt; r0 = rd_cnt;
    start_save = 1'b1; start_load = 1'b1;
    step();
    start_save = 1'b0; start_load = 1'b0;
    repeat (20) step();
    start_load = 1'b1;
    step();
    start_load = 1'b0;
    n = 0;
    while (!done && n < 2000) begin step(); n++; end
    repeat (3) step();
    check("both_one_done", 64'(done_cnt - d0), 64'd1);
    check("both_no_reads", 64'(rd_cnt - r0), 64'd0);
    check("both_save_data", 64'(save_bad()), 64'd0);
    check("both_idle_after", 64'(busy), 64'd0);

    // abort during LD_WE at idx 40, then late ack, then restart from 0
    fill();
    start_load = 1'b1;
    step();
    start_load = 1'b0;
    n = 0;
    while (!(bus.ss_we && bus.ss_addr == 8'd40) && n < 3000) begin step(); n++; end
    hit = bus.ss_we && (bus.ss_addr == 8'd40);
    check("abort_reach", 64'(hit), 64'd1);
    d0 = done_cnt;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_outputs", 64'({busy, done, bus.ss_act, bus.ss_we, bus.mem_req}), 64'd0);
    repeat (2) step();
    late_ack = 1'b1;
    step();
    late_ack = 1'b0;
    step();
    check("late_ack_ignored", 64'({busy, bus.mem_req, bus.ss_act}), 64'd0);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    fill();
    start_save = 1'b1;
    step();
    start_save = 1'b0;
    check("restart_idx0", 64'({bus.ss_act, bus.ss_addr, bus.mem_addr}), 64'({1'b1, 8'h00, 8'h00}));
    n = 0;
    while (!done && n < 2000) begin step(); n++; end
    check("restart_done", 64'(done), 64'd1);
    check("restart_data", 64'(save_bad()), 64'd0);
    step();

    // rst_n low for one cycle mid-save at idx 100
    start_save = 1'b1;
    step();
    start_save = 1'b0;
    n = 0;
    while (!(bus.ss_act && bus.ss_addr == 8'd100) && n < 2000) begin step(); n++; end
    hit = bus.ss_act && (bus.ss_addr == 8'd100);
    check("reset_reach", 64'(hit), 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("reset_outputs",
          64'({busy, done, bus.ss_act, bus.ss_we, bus.mem_req, bus.mem_wr,
               bus.ss_addr, bus.ss_wdat, bus.mem_addr, bus.mem_wdat}), 64'd0);
    step();
    check("reset_stays_idle", 64'({busy, bus.ss_act, bus.mem_req}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
